// File: rtl/elevator_pkg.sv
// Shared floor codes, FSM state encoding and helpers for the elevator call scheduler.
package elevator_pkg;

    localparam logic [1:0] FLOOR_A    = 2'b00;
    localparam logic [1:0] FLOOR_B    = 2'b01;
    localparam logic [1:0] FLOOR_C    = 2'b10;
    localparam logic [1:0] FLOOR_NONE = 2'b11;

    localparam int DWELL_TICKS_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLOSE_WAIT = 3'd1,
        ST_MOVE       = 3'd2,
        ST_DOOR       = 3'd3,
        ST_HALT       = 3'd4
    } state_t;

    // One-hot call mask for a floor code; "between floors" maps to no floor.
    function automatic logic [2:0] floor_onehot(input logic [1:0] floor_code);
        logic [2:0] oh;
        case (floor_code)
            FLOOR_A: oh = 3'b001;
            FLOOR_B: oh = 3'b010;
            FLOOR_C: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/elevator_target_select.sv
// SCAN target selection: nearest pending floor ahead in the sweep, else nearest behind
// with the sweep reversed; a pending call at the current floor always wins.
module elevator_target_select
    import elevator_pkg::*;
(
    input  logic [2:0] pending_i,
    input  logic [1:0] cur_floor_i,
    input  logic       dir_up_i,
    output logic [1:0] target_o,
    output logic       target_valid_o,
    output logic       next_dir_up_o
);

    // Behind is scanned first and ahead second, each far-to-near, so the last hit is the answer.
    always_comb begin
        int cur_int;
        int f_int;
        target_o       = cur_floor_i;
        target_valid_o = 1'b0;
        next_dir_up_o  = dir_up_i;
        cur_int        = int'(cur_floor_i);
        f_int          = 0;
        if (cur_floor_i == FLOOR_NONE) begin
            target_valid_o = 1'b0;
        end else if ((pending_i & floor_onehot(cur_floor_i)) != 3'b000) begin
            target_valid_o = 1'b1;
        end else begin
            for (int d = 2; d >= 1; d--) begin
                f_int = dir_up_i ? (cur_int - d) : (cur_int + d);
                if (f_int >= 0 && f_int <= 2 &&
                    (pending_i & floor_onehot(f_int[1:0])) != 3'b000) begin
                    target_o       = f_int[1:0];
                    target_valid_o = 1'b1;
                    next_dir_up_o  = ~dir_up_i;
                end else begin
                    target_valid_o = target_valid_o;
                end
            end
            for (int d = 2; d >= 1; d--) begin
                f_int = dir_up_i ? (cur_int + d) : (cur_int - d);
                if (f_int >= 0 && f_int <= 2 &&
                    (pending_i & floor_onehot(f_int[1:0])) != 3'b000) begin
                    target_o       = f_int[1:0];
                    target_valid_o = 1'b1;
                    next_dir_up_o  = dir_up_i;
                end else begin
                    target_valid_o = target_valid_o;
                end
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective-control scheduler for a 3-floor car: call register, SCAN sequencing FSM,
// door dwell counter. All outputs are registered.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int DWELL_TICKS = DWELL_TICKS_DEF,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] call_ext,
    input  logic [2:0] call_int,
    input  logic [1:0] cur_floor,
    input  logic       door_closed,
    input  logic       alarm,
    output logic [2:0] pending,
    output logic [1:0] target,
    output logic       target_valid,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open_req,
    output logic       dir_up,
    output logic       halted
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       pending_q, pending_d;
    logic [1:0]       target_q, target_d;
    logic             target_valid_q, target_valid_d;
    logic             motor_up_q, motor_up_d;
    logic             motor_down_q, motor_down_d;
    logic             door_q, door_d;
    logic             dir_up_q, dir_up_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [1:0]       last_floor_q, last_floor_d;

    logic       cur_valid_s;
    logic [1:0] pos_s;
    logic [2:0] cur_oh_s;
    logic       cur_call_s;
    logic [2:0] clr_mask_s;
    logic [1:0] sel_target_s, mv_target_s;
    logic       sel_valid_s, mv_valid_s;
    logic       sel_dir_s, mv_dir_s;

    // Between floors the car is located by the last floor it passed.
    assign cur_valid_s = (cur_floor != FLOOR_NONE);
    assign pos_s       = cur_valid_s ? cur_floor : last_floor_q;
    assign cur_oh_s    = floor_onehot(cur_floor);
    assign cur_call_s  = ((call_ext | call_int) & cur_oh_s) != 3'b000;

    elevator_target_select u_sel_idle (
        .pending_i      (pending_q),
        .cur_floor_i    (pos_s),
        .dir_up_i       (dir_up_q),
        .target_o       (sel_target_s),
        .target_valid_o (sel_valid_s),
        .next_dir_up_o  (sel_dir_s)
    );

    // While moving, the floor just left is excluded so only floors still ahead can retarget.
    elevator_target_select u_sel_move (
        .pending_i      (pending_q & ~floor_onehot(pos_s)),
        .cur_floor_i    (pos_s),
        .dir_up_i       (dir_up_q),
        .target_o       (mv_target_s),
        .target_valid_o (mv_valid_s),
        .next_dir_up_o  (mv_dir_s)
    );

    // Next-state, target/direction latch and dwell counter.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_up_d = dir_up_q;
        dwell_d  = dwell_q;
        case (state_q)
            ST_IDLE: begin
                if (alarm) begin
                    state_d = ST_HALT;
                end else if (cur_valid_s && (pending_q & cur_oh_s) != 3'b000) begin
                    state_d  = ST_DOOR;
                    target_d = cur_floor;
                    dwell_d  = CNT_ZERO;
                end else if (sel_valid_s) begin
                    state_d  = ST_CLOSE_WAIT;
                    target_d = sel_target_s;
                    dir_up_d = sel_dir_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLOSE_WAIT: begin
                if (alarm) begin
                    state_d = ST_HALT;
                end else if (door_closed) begin
                    state_d = ST_MOVE;
                end else begin
                    state_d = ST_CLOSE_WAIT;
                end
            end
            ST_MOVE: begin
                if (cur_valid_s && cur_floor == target_q) begin
                    state_d = ST_DOOR;
                    dwell_d = CNT_ZERO;
                end else if (mv_valid_s) begin
                    target_d = mv_target_s;
                    dir_up_d = mv_dir_s;
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_DOOR: begin
                if (alarm) begin
                    state_d = ST_HALT;
                end else if (cur_call_s) begin
                    dwell_d = CNT_ZERO;
                end else if (tick) begin
                    if (dwell_q == DWELL_LAST) begin
                        state_d = ST_IDLE;
                        dwell_d = CNT_ZERO;
                    end else begin
                        dwell_d = dwell_q + CNT_ONE;
                    end
                end else begin
                    dwell_d = dwell_q;
                end
            end
            ST_HALT: begin
                if (!alarm) begin
                    state_d = ST_DOOR;
                    dwell_d = CNT_ZERO;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dwell_d = CNT_ZERO;
            end
        endcase
    end

    // Call latch; the current floor is masked for as long as the door is being served there.
    always_comb begin
        if (state_d == ST_DOOR) begin
            clr_mask_s = cur_oh_s;
        end else begin
            clr_mask_s = 3'b000;
        end
        pending_d = (pending_q | call_ext | call_int) & ~clr_mask_s;
    end

    // Registered output values derived from the next state.
    always_comb begin
        motor_up_d     = 1'b0;
        motor_down_d   = 1'b0;
        target_valid_d = (state_d == ST_CLOSE_WAIT) || (state_d == ST_MOVE);
        door_d         = (state_d == ST_DOOR) || (state_d == ST_HALT && cur_valid_s);
        halted_d       = (state_d == ST_HALT);
        last_floor_d   = pos_s;
        if (state_d == ST_MOVE) begin
            if (cur_valid_s) begin
                motor_up_d   = (target_d > cur_floor);
                motor_down_d = (target_d < cur_floor);
            end else begin
                motor_up_d   = motor_up_q;
                motor_down_d = motor_down_q;
            end
        end else begin
            motor_up_d   = 1'b0;
            motor_down_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pending_q      <= 3'b000;
            target_q       <= FLOOR_A;
            target_valid_q <= 1'b0;
            motor_up_q     <= 1'b0;
            motor_down_q   <= 1'b0;
            door_q         <= 1'b0;
            dir_up_q       <= 1'b1;
            halted_q       <= 1'b0;
            dwell_q        <= CNT_ZERO;
            last_floor_q   <= FLOOR_A;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            target_q       <= target_d;
            target_valid_q <= target_valid_d;
            motor_up_q     <= motor_up_d;
            motor_down_q   <= motor_down_d;
            door_q         <= door_d;
            dir_up_q       <= dir_up_d;
            halted_q       <= halted_d;
            dwell_q        <= dwell_d;
            last_floor_q   <= last_floor_d;
        end
    end

    assign pending       = pending_q;
    assign target        = target_q;
    assign target_valid  = target_valid_q;
    assign motor_up      = motor_up_q;
    assign motor_down    = motor_down_q;
    assign door_open_req = door_q;
    assign dir_up        = dir_up_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed scenarios with hand-derived expectations, then randomized traffic against a
// car/shaft model that checks every call is served and no stop happens without a call.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       reset, tick, door_closed, alarm;
    logic [2:0] call_ext, call_int;
    logic [1:0] cur_floor;
    logic [2:0] pending;
    logic [1:0] target;
    logic       target_valid, motor_up, motor_down, door_open_req, dir_up, halted;

    int vectors    = 0;
    int miscompares = 0;

    elevator_call_scheduler #(.DWELL_TICKS(3), .CNT_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .call_ext      (call_ext),
        .call_int      (call_int),
        .cur_floor     (cur_floor),
        .door_closed   (door_closed),
        .alarm         (alarm),
        .pending       (pending),
        .target        (target),
        .target_valid  (target_valid),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .door_open_req (door_open_req),
        .dir_up        (dir_up),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pending"}, 8'(pending), 8'(3'b000));
        chk({tag, "_target"}, 8'(target), 8'(2'b00));
        chk({tag, "_tvalid"}, 8'(target_valid), 8'(1'b0));
        chk({tag, "_motors"}, 8'({motor_up, motor_down}), 8'(2'b00));
        chk({tag, "_door"}, 8'(door_open_req), 8'(1'b0));
        chk({tag, "_dir"}, 8'(dir_up), 8'(1'b1));
        chk({tag, "_halted"}, 8'(halted), 8'(1'b0));
    endtask

    task automatic three_ticks(input string tag);
        pulse_tick();
        chk({tag, "_t1"}, 8'(door_open_req), 8'(1'b1));
        pulse_tick();
        chk({tag, "_t2"}, 8'(door_open_req), 8'(1'b1));
        pulse_tick();
        chk({tag, "_t3"}, 8'(door_open_req), 8'(1'b0));
    endtask

    initial begin
        int         p;
        logic [2:0] outstanding;
        logic [2:0] new_calls;
        logic       prev_door;

        reset = 1'b1; tick = 1'b0; door_closed = 1'b1; alarm = 1'b0;
        call_ext = 3'b000; call_int = 3'b000; cur_floor = 2'b00;
        cyc(2);
        chk_reset_state("reset");
        reset = 1'b0;
        cyc(1);

        // A_i at floor A: latched one edge later, then served with a 3-tick dwell.
        call_int = 3'b001; cyc(1);
        chk("s1_latch", 8'(pending), 8'(3'b001));
        call_int = 3'b000; cyc(1);
        chk("s1_door", 8'(door_open_req), 8'(1'b1));
        chk("s1_clear", 8'(pending), 8'(3'b000));
        three_ticks("s1_dwell");

        // C_e at A: wait for door, drive up, stop at C.
        door_closed = 1'b0;
        call_ext = 3'b100; cyc(1);
        chk("s2_latch", 8'(pending), 8'(3'b100));
        call_ext = 3'b000; cyc(1);
        chk("s2_target", 8'(target), 8'(2'b10));
        chk("s2_tvalid", 8'(target_valid), 8'(1'b1));
        cyc(2);
        chk("s2_cw_motor", 8'(motor_up), 8'(1'b0));
        door_closed = 1'b1; cyc(1);
        chk("s2_up", 8'({motor_up, motor_down}), 8'(2'b10));
        cur_floor = 2'b11; cyc(3);
        chk("s2_keep_up", 8'(motor_up), 8'(1'b1));
        cur_floor = 2'b01; cyc(1);
        chk("s2_pass_b", 8'({motor_up, target}), 8'(3'b110));
        cur_floor = 2'b11; cyc(1);
        cur_floor = 2'b10; cyc(1);
        chk("s2_arrive_motor", 8'(motor_up), 8'(1'b0));
        chk("s2_arrive_door", 8'(door_open_req), 8'(1'b1));
        chk("s2_arrive_pend", 8'(pending), 8'(3'b000));
        three_ticks("s2_dwell");

        // Heading down from C, reset between floors drops everything.
        call_int = 3'b001; cyc(1);
        call_int = 3'b000; cyc(1);
        chk("s6_target", 8'({target, dir_up}), 8'(3'b000));
        cyc(1);
        chk("s6_down", 8'({motor_up, motor_down}), 8'(2'b01));
        cur_floor = 2'b11; cyc(1);
        chk("s6_keep_down", 8'(motor_down), 8'(1'b1));
        reset = 1'b1; cyc(1);
        chk_reset_state("s6_reset");
        reset = 1'b0; cur_floor = 2'b01; cyc(1);

        // At B sweeping up with A and C pending: C first, then A with the sweep reversed.
        call_ext = 3'b101; cyc(1);
        chk("s3_latch", 8'(pending), 8'(3'b101));
        call_ext = 3'b000; cyc(1);
        chk("s3_target_c", 8'({target, dir_up}), 8'(3'b101));
        cyc(1);
        chk("s3_up", 8'(motor_up), 8'(1'b1));
        cur_floor = 2'b11; cyc(2);
        cur_floor = 2'b10; cyc(1);
        chk("s3_at_c", 8'({door_open_req, motor_up}), 8'(2'b10));
        chk("s3_pend_a", 8'(pending), 8'(3'b001));
        three_ticks("s3_dwell_c");
        cyc(1);
        chk("s3_target_a", 8'({target, dir_up}), 8'(3'b000));
        cyc(1);
        chk("s3_down", 8'(motor_down), 8'(1'b1));
        cur_floor = 2'b11; cyc(2);
        cur_floor = 2'b01; cyc(1);
        chk("s3_pass_b", 8'(motor_down), 8'(1'b1));
        cur_floor = 2'b11; cyc(1);
        cur_floor = 2'b00; cyc(1);
        chk("s3_at_a", 8'({door_open_req, motor_down}), 8'(2'b10));
        chk("s3_pend_none", 8'(pending), 8'(3'b000));
        three_ticks("s3_dwell_a");

        // A->C run: B_e between A and B retargets to B; A_e after leaving A waits.
        call_ext = 3'b100; cyc(1);
        call_ext = 3'b000; cyc(1);
        chk("s4_target_c", 8'({target, dir_up}), 8'(3'b101));
        cyc(1);
        chk("s4_up", 8'(motor_up), 8'(1'b1));
        cur_floor = 2'b11; call_ext = 3'b010; cyc(1);
        call_ext = 3'b000; cyc(1);
        chk("s4_retarget_b", 8'(target), 8'(2'b01));
        call_ext = 3'b001; cyc(1);
        call_ext = 3'b000;
        chk("s4_a_behind", 8'({pending, target}), 8'(5'b11101));
        cur_floor = 2'b01; cyc(1);
        chk("s4_stop_b", 8'({door_open_req, motor_up}), 8'(2'b10));
        chk("s4_pend", 8'(pending), 8'(3'b101));
        three_ticks("s4_dwell_b");
        cyc(1);
        chk("s4_then_c", 8'({target, dir_up}), 8'(3'b101));
        cyc(1);
        cur_floor = 2'b11; cyc(2);
        cur_floor = 2'b10; cyc(1);
        chk("s4_at_c", 8'({door_open_req, pending}), 8'(4'b1001));

        // Alarm during dwell at C: HALT holds through ticks, then a full fresh dwell.
        pulse_tick();
        alarm = 1'b1; cyc(1);
        chk("s5_halt", 8'({halted, door_open_req, motor_up, motor_down}), 8'(4'b1100));
        repeat (4) pulse_tick();
        chk("s5_halt_hold", 8'({halted, motor_up, motor_down}), 8'(3'b100));
        call_int = 3'b010; cyc(1);
        call_int = 3'b000;
        chk("s5_halt_latch", 8'(pending), 8'(3'b011));
        alarm = 1'b0; cyc(1);
        chk("s5_resume", 8'({halted, door_open_req}), 8'(2'b01));
        pulse_tick();
        pulse_tick();
        call_ext = 3'b100; cyc(1);
        call_ext = 3'b000;
        chk("s5_restart_pend", 8'({door_open_req, pending}), 8'(4'b1011));
        three_ticks("s5_dwell");
        cyc(1);
        chk("s5_next", 8'({target, dir_up, target_valid}), 8'(4'b0101));

        // Randomized traffic on a simple shaft model: 4 clk per floor, door closes when released.
        reset = 1'b1; cur_floor = 2'b00; door_closed = 1'b1; alarm = 1'b0;
        call_ext = 3'b000; call_int = 3'b000; tick = 1'b0;
        cyc(2);
        reset = 1'b0;
        p = 0; outstanding = 3'b000; prev_door = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            chk("rnd_motor_excl", 8'(motor_up & motor_down), 8'(1'b0));
            if (halted || door_open_req) begin
                chk("rnd_motor_idle", 8'({motor_up, motor_down}), 8'(2'b00));
            end
            if (door_open_req && !prev_door && !halted && cur_floor != 2'b11) begin
                chk("rnd_stop_reason", 8'(outstanding[cur_floor]), 8'(1'b1));
            end
            if (door_open_req && cur_floor != 2'b11) begin
                outstanding[cur_floor] = 1'b0;
            end
            prev_door = door_open_req;

            if (motor_up && p < 8) p++;
            else if (motor_down && p > 0) p--;
            cur_floor   = ((p % 4) == 0) ? 2'(p / 4) : 2'b11;
            door_closed = ~door_open_req;
            tick        = ((i % 6) == 0) ? 1'b1 : 1'b0;

            call_ext = 3'b000;
            call_int = 3'b000;
            if (i < 2500) begin
                if ($urandom_range(0, 39) == 0) call_ext = 3'b001 << $urandom_range(0, 2);
                if ($urandom_range(0, 39) == 0) call_int = 3'b001 << $urandom_range(0, 2);
                if (!alarm && $urandom_range(0, 199) == 0) alarm = 1'b1;
                else if (alarm && $urandom_range(0, 7) == 0) alarm = 1'b0;
            end else begin
                alarm = 1'b0;
            end
            new_calls = call_ext | call_int;
            for (int f = 0; f < 3; f++) begin
                if (new_calls[f] && !(door_open_req && cur_floor == 2'(f))) outstanding[f] = 1'b1;
            end
            cyc(1);
        end
        chk("rnd_end_pending", 8'(pending), 8'(3'b000));
        chk("rnd_end_served", 8'(outstanding), 8'(3'b000));
        chk("rnd_end_outputs", 8'({motor_up, motor_down, door_open_req, halted}), 8'(4'b0000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
